// File: rtl/cnn_frame_seq_fsm.sv
// Frame sequencer for the CNN conv datapath: vsync delay, then per row an hsync
// delay followed by one pixel per cycle, with a frame-done handshake.
module cnn_frame_seq_fsm #(
  parameter int unsigned W_SIZE       = 12,
  parameter int unsigned W_DELAY      = 12,
  parameter int unsigned W_FRAME_SIZE = 25
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    q_is_conv3x3,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_DELAY-1:0]      q_start_up_delay,
  input  logic [W_DELAY-1:0]      q_hsync_delay,
  input  logic [W_FRAME_SIZE-1:0] q_frame_size,
  input  logic                    q_start,
  output logic                    o_ctrl_vsync_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic                    o_ctrl_hsync_run,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic                    o_ctrl_data_run,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VSYNC = 3'd1,
    S_HSYNC = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [W_DELAY-1:0]      vsync_cnt_q, vsync_cnt_d;
  logic [W_DELAY-1:0]      hsync_cnt_q, hsync_cnt_d;
  logic [W_SIZE-1:0]       row_q, row_d;
  logic [W_SIZE-1:0]       col_q, col_d;
  logic [W_FRAME_SIZE-1:0] data_count_q, data_count_d;

  logic [W_DELAY-1:0] vsync_last;
  logic [W_DELAY-1:0] hsync_last;
  logic               row_last;
  logic               col_last;
  logic               count_last;

  // Layer type does not influence sequencing.
  logic unused_conv3x3;
  assign unused_conv3x3 = q_is_conv3x3;

  // Terminal counts; a zero delay still costs one cycle.
  always_comb begin
    vsync_last = (q_start_up_delay == '0) ? '0 : q_start_up_delay - W_DELAY'(1);
    hsync_last = (q_hsync_delay == '0) ? '0 : q_hsync_delay - W_DELAY'(1);
    row_last   = (row_q == q_height - W_SIZE'(1));
    col_last   = (col_q == q_width - W_SIZE'(1));
    count_last = (data_count_q == q_frame_size - W_FRAME_SIZE'(1));
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d      = state_q;
    vsync_cnt_d  = vsync_cnt_q;
    hsync_cnt_d  = hsync_cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    data_count_d = data_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (q_start) begin
          state_d      = S_VSYNC;
          vsync_cnt_d  = '0;
          row_d        = '0;
          col_d        = '0;
          data_count_d = '0;
        end
      end
      S_VSYNC: begin
        if (vsync_cnt_q == vsync_last) begin
          state_d     = S_HSYNC;
          vsync_cnt_d = '0;
          hsync_cnt_d = '0;
        end else begin
          vsync_cnt_d = vsync_cnt_q + W_DELAY'(1);
        end
      end
      S_HSYNC: begin
        if (hsync_cnt_q == hsync_last) begin
          state_d     = S_DATA;
          hsync_cnt_d = '0;
          col_d       = '0;
        end else begin
          hsync_cnt_d = hsync_cnt_q + W_DELAY'(1);
        end
      end
      S_DATA: begin
        // Last pixel of the frame keeps its coordinates through DONE.
        if (count_last || (col_last && row_last)) begin
          state_d = S_DONE;
        end else if (col_last) begin
          state_d      = S_HSYNC;
          hsync_cnt_d  = '0;
          row_d        = row_q + W_SIZE'(1);
          col_d        = '0;
          data_count_d = data_count_q + W_FRAME_SIZE'(1);
        end else begin
          col_d        = col_q + W_SIZE'(1);
          data_count_d = data_count_q + W_FRAME_SIZE'(1);
        end
      end
      S_DONE: begin
        if (!q_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      vsync_cnt_q  <= '0;
      hsync_cnt_q  <= '0;
      row_q        <= '0;
      col_q        <= '0;
      data_count_q <= '0;
    end else begin
      state_q      <= state_d;
      vsync_cnt_q  <= vsync_cnt_d;
      hsync_cnt_q  <= hsync_cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      data_count_q <= data_count_d;
    end
  end

  assign o_ctrl_vsync_run = (state_q == S_VSYNC);
  assign o_ctrl_hsync_run = (state_q == S_HSYNC);
  assign o_ctrl_data_run  = (state_q == S_DATA);
  assign o_end_frame      = (state_q == S_DONE);
  assign o_ctrl_vsync_cnt = vsync_cnt_q;
  assign o_ctrl_hsync_cnt = hsync_cnt_q;
  assign o_row            = row_q;
  assign o_col            = col_q;
  assign o_data_count     = data_count_q;

endmodule

// File: tb/tb_cnn_frame_seq_fsm.sv
// Bench for cnn_frame_seq_fsm: per-cycle expected frame trace queued from a
// reference scan model, popped and compared as the frame runs.
module tb_cnn_frame_seq_fsm;

  localparam int unsigned W_SIZE       = 12;
  localparam int unsigned W_DELAY      = 12;
  localparam int unsigned W_FRAME_SIZE = 25;

  logic                    HCLK = 1'b0;
  logic                    HRESETn = 1'b0;
  logic                    q_is_conv3x3 = 1'b0;
  logic [W_SIZE-1:0]       q_width = '0;
  logic [W_SIZE-1:0]       q_height = '0;
  logic [W_DELAY-1:0]      q_start_up_delay = '0;
  logic [W_DELAY-1:0]      q_hsync_delay = '0;
  logic [W_FRAME_SIZE-1:0] q_frame_size = '0;
  logic                    q_start = 1'b0;
  logic                    o_ctrl_vsync_run;
  logic [W_DELAY-1:0]      o_ctrl_vsync_cnt;
  logic                    o_ctrl_hsync_run;
  logic [W_DELAY-1:0]      o_ctrl_hsync_cnt;
  logic                    o_ctrl_data_run;
  logic [W_SIZE-1:0]       o_row;
  logic [W_SIZE-1:0]       o_col;
  logic [W_FRAME_SIZE-1:0] o_data_count;
  logic                    o_end_frame;

  cnn_frame_seq_fsm #(
    .W_SIZE(W_SIZE), .W_DELAY(W_DELAY), .W_FRAME_SIZE(W_FRAME_SIZE)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .q_is_conv3x3(q_is_conv3x3),
    .q_width(q_width), .q_height(q_height),
    .q_start_up_delay(q_start_up_delay), .q_hsync_delay(q_hsync_delay),
    .q_frame_size(q_frame_size), .q_start(q_start),
    .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt),
    .o_ctrl_hsync_run(o_ctrl_hsync_run), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
    .o_ctrl_data_run(o_ctrl_data_run), .o_row(o_row), .o_col(o_col),
    .o_data_count(o_data_count), .o_end_frame(o_end_frame)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit v;
    bit h;
    bit d;
    int vc;
    int hc;
    int row;
    int col;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] pack_obs();
    return 64'({o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run, o_end_frame,
                o_row, o_col, o_data_count});
  endfunction

  function automatic logic [63:0] pack_exp(input bit v, input bit h, input bit d, input bit e,
                                           input int row, input int col, input int cnt);
    return 64'({v, h, d, e, W_SIZE'(row), W_SIZE'(col), W_FRAME_SIZE'(cnt)});
  endfunction

  function automatic exp_t mk(input bit v, input bit h, input bit d, input int vc,
                              input int hc, input int row, input int col, input int cnt);
    exp_t e;
    e.v = v; e.h = h; e.d = d; e.vc = vc; e.hc = hc;
    e.row = row; e.col = col; e.cnt = cnt;
    return e;
  endfunction

  // Run one frame; queue the expected per-cycle trace, then pop and compare.
  task automatic run_frame(input string tag, input int w, input int h, input int sd,
                           input int hd, input int fs, input bit hold, input int exp_len);
    int   sdp, hdp, len, lr, lc, lcnt;
    bit   stop;
    exp_t e;
    sdp = (sd == 0) ? 1 : sd;
    hdp = (hd == 0) ? 1 : hd;
    stop = 1'b0;
    lr = 0; lc = 0; lcnt = 0;
    exp_q.delete();
    for (int s = 0; s < sdp; s++) exp_q.push_back(mk(1, 0, 0, s, 0, 0, 0, 0));
    for (int r = 0; r < h && !stop; r++) begin
      for (int k = 0; k < hdp; k++) exp_q.push_back(mk(0, 1, 0, 0, k, r, 0, r * w));
      for (int c = 0; c < w && !stop; c++) begin
        exp_q.push_back(mk(0, 0, 1, 0, 0, r, c, r * w + c));
        lr = r; lc = c; lcnt = r * w + c;
        if (r * w + c == fs - 1) stop = 1'b1;
      end
    end

    @(negedge HCLK);
    q_width          = W_SIZE'(w);
    q_height         = W_SIZE'(h);
    q_start_up_delay = W_DELAY'(sd);
    q_hsync_delay    = W_DELAY'(hd);
    q_frame_size     = W_FRAME_SIZE'(fs);
    q_start          = 1'b1;
    @(negedge HCLK);
    if (!hold) q_start = 1'b0;

    len = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_trace"}, pack_obs(), pack_exp(e.v, e.h, e.d, 0, e.row, e.col, e.cnt));
      if (e.v) check({tag, "_vcnt"}, 64'(o_ctrl_vsync_cnt), 64'(e.vc));
      if (e.h) check({tag, "_hcnt"}, 64'(o_ctrl_hsync_cnt), 64'(e.hc));
      if (o_ctrl_vsync_run || o_ctrl_hsync_run || o_ctrl_data_run) len++;
      @(negedge HCLK);
    end
    check({tag, "_done"}, pack_obs(), pack_exp(0, 0, 0, 1, lr, lc, lcnt));
    check({tag, "_len"}, 64'(len), 64'(exp_len));
  endtask

  initial begin
    int budget;

    // Reset state
    repeat (3) @(negedge HCLK);
    check("reset_outputs", pack_obs(), pack_exp(0, 0, 0, 0, 0, 0, 0));
    check("reset_cnts", 64'({o_ctrl_vsync_cnt, o_ctrl_hsync_cnt}), 64'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("idle_no_start", pack_obs(), pack_exp(0, 0, 0, 0, 0, 0, 0));

    // Nominal frame: W=4 H=3 SD=5 HD=2 -> 23 cycles, ends at row2 col3 count11
    run_frame("nominal", 4, 3, 5, 2, 1000, 1'b0, 23);
    @(negedge HCLK);
    check("nominal_idle", pack_obs(), pack_exp(0, 0, 0, 0, 2, 3, 11));

    // Zero delays take one cycle each: 1 + 2*(1+2) = 7
    run_frame("zero_delay", 2, 2, 0, 0, 1000, 1'b0, 7);
    @(negedge HCLK);

    // Frame-size limit stops at count 5 (row1 col1): 5 + 6 + 4 = 15
    run_frame("fs_limit", 4, 3, 5, 2, 6, 1'b0, 15);
    @(negedge HCLK);

    // Asynchronous reset mid-DATA
    q_width = 12'd4; q_height = 12'd3; q_start_up_delay = 12'd5;
    q_hsync_delay = 12'd2; q_frame_size = 25'd1000;
    q_start = 1'b1;
    @(negedge HCLK);
    q_start = 1'b0;
    budget = 0;
    while (!o_ctrl_data_run && budget < 50) begin
      @(negedge HCLK);
      budget++;
    end
    check("rst_reach_data", 64'(o_ctrl_data_run), 64'd1);
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_async", pack_obs(), pack_exp(0, 0, 0, 0, 0, 0, 0));
    @(negedge HCLK);
    check("rst_held", pack_obs(), pack_exp(0, 0, 0, 0, 0, 0, 0));
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    check("rst_no_restart", pack_obs(), pack_exp(0, 0, 0, 0, 0, 0, 0));

    // Handshake: start held through DONE, then dropped, then raised again
    run_frame("hold", 2, 1, 1, 1, 1000, 1'b1, 4);
    repeat (5) @(negedge HCLK);
    check("hold_stays_done", pack_obs(), pack_exp(0, 0, 0, 1, 0, 1, 1));
    q_start = 1'b0;
    @(negedge HCLK);
    check("drop_to_idle", pack_obs(), pack_exp(0, 0, 0, 0, 0, 1, 1));
    q_width = 12'd3; q_height = 12'd2; q_start_up_delay = 12'd2;
    q_start = 1'b1;
    @(negedge HCLK);
    q_start = 1'b0;
    check("restart_cleared", pack_obs(), pack_exp(1, 0, 0, 0, 0, 0, 0));
    check("restart_vcnt", 64'(o_ctrl_vsync_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
